inst_encoder: RTL
=================

# inst_encoder

- Streaming RV32 instruction encoder: the inverse of the core's immediate/field decode path.
- Accepts decoded fields (opcode, registers, funct, full 32-bit immediate) over a valid/ready handshake and packs them into a 32-bit instruction word.
- Writes each word into instruction memory through a backpressured write port, at auto-incrementing byte addresses.
- Used by the self-test loader and the bench program builder to fill instruction memory before the core is released from reset.

## Interface
- `ADDR_W`, 12 — width of the byte address on the write port.
- `BASE_ADDR`, 0 — byte address of the first word written after `start`; word-aligned.
- `DEPTH`, 256 — maximum number of words written per session.
- `clk`  in  1  — single clock; all logic on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — begin a new session: load `BASE_ADDR`, clear count and errors, drop any pending write.
- `in_valid`  in  1  — field bundle valid.
- `in_ready`  out  1  — bundle accepted when `in_valid && in_ready`.
- `in_opcode`  in  7  — instruction opcode, bits [6:0].
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  — register indices.
- `in_funct3`  in  3 / `in_funct7`  in  7  — function fields.
- `in_imm`  in  32  — signed immediate (U-type: the full 32-bit value).
- `wr_en`  out  1  — memory write request.
- `wr_ready`  in  1  — memory accepts the write when `wr_en && wr_ready`.
- `wr_addr`  out  `ADDR_W`  — byte address.
- `wr_data`  out  32  — encoded instruction.
- `count`  out  `ADDR_W+1`  — words written this session.
- `full`  out  1  — `DEPTH` words written.
- `busy`  out  1  — state is RUN.
- `err_opcode`  out  1  — sticky: an unsupported opcode was received.
- `err_imm`  out  1  — sticky: an immediate was out of range (macro only).

## Operation
- **FSM states:** IDLE, RUN, FULL.
  - Reset → IDLE.
  - `start` in any state → RUN.
  - RUN → FULL when a write completes and `count` becomes `DEPTH`.
  - FULL and IDLE hold until `start`.
- **`in_ready` in RUN** = `!start && (!wr_en || wr_ready) && (issued < DEPTH)`.
  - `issued` counts bundles accepted and destined for memory.
  - `in_ready` is 0 in IDLE and FULL.
- **Encoding by `in_opcode`:**
  - 0110011 R: {funct7, rs2, rs1, funct3, rd, op}
  - 0000011 / 0010011 I: {imm[11:0], rs1, funct3, rd, op}
  - 0100011 S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
  - 1100011 B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
  - 0110111 U: {imm[31:12], rd, op}
- **Unsupported opcode:** the bundle is accepted and consumed, with no write and no count change; `err_opcode` is set.
- **Output register:** a one-entry register holds `wr_en`/`wr_addr`/`wr_data`.
  - On a write handshake: `wr_addr += 4`, `count += 1`.
  - Address wraps modulo 2^`ADDR_W`.
- **`start` with a write pending:** the write is dropped and `wr_en` clears on the next edge. `start` has priority over a simultaneous `in_valid`.

## Timing
- **Reset values:** all outputs 0 except `wr_addr = BASE_ADDR`; state IDLE.
- **Latency:** a bundle accepted at edge N drives `wr_en=1` with its data in cycle N+1.
- **Throughput:** one word per cycle while `wr_ready=1` (accept and write in the same cycle).
- **Stability:** while `wr_en && !wr_ready`, `wr_addr` and `wr_data` stay stable and `in_ready=0`.
- **Flags:** `full` and `busy` are registered and follow the state. `err_*` update on the edge after the offending handshake.

## Configuration
- **Macro:** `INST_ENC_IMM_CHECK_EN`.
- **Defined:** the immediate is range-checked on acceptance.
  - I/S: must sign-fit 12 bits.
  - B: must sign-fit 13 bits, and `imm[0]` must be 0.
  - U: `imm[11:0]` must be 0.
  - A violating bundle is consumed without a write; `err_imm` is set.
- **Undefined:** no check. Out-of-range bits are silently truncated, the word is written, and `err_imm` stays 0.

## Test plan
- **Encodings:** `start`, then send:
  - addi x1,x0,-1 → `wr_data=0xFFF00093` at `wr_addr=BASE_ADDR`.
  - sw x2,8(x1) → `0x0020A423` at +4.
  - beq x0,x0,-4 → `0xFE000EE3` at +8.
  - lui x5,0x12345000 → `0x123452B7` at +12.
  - Then `count=4`.
- **Backpressure:** hold `wr_ready=0` for 3 cycles with `wr_en=1` → `wr_addr`/`wr_data` stable, `in_ready=0`; write completes on the first `wr_ready=1` cycle.
- **Full:** `DEPTH=4`, stream 6 bundles with `wr_ready=1` → exactly 4 writes, then `full=1`, `in_ready=0`. A later `start` → `wr_addr=BASE_ADDR`, `count=0`, `busy=1`.
- **Bad opcode:** opcode 1111111 → no `wr_en`, `count` unchanged, `err_opcode=1` until the next `start`.
- **Immediate range:** addi x1,x0,2048.
  - With the macro: `err_imm=1`, no write.
  - Without the macro: write of `0x80000093`.
- **Reset:** `rst` mid-stream with a write pending → next cycle `wr_en=0`, `count=0`, state IDLE, `in_ready=0`.

Source files
------------

// File: rtl/inst_encoder.sv
// Streaming RV32 instruction encoder: packs decoded fields into 32-bit words and writes them
// to instruction memory at auto-incrementing byte addresses, starting at BASE_ADDR.
// Latency: a bundle accepted at edge N presents wr_en/wr_data in cycle N+1.
// Backpressure: one-entry output register; in_ready drops while a write is stalled by wr_ready=0.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   start               - open a new session (base address, clear count/errors, drop pending write)
//   in_valid / in_ready - field bundle handshake (in_opcode, in_rd, in_rs1, in_rs2,
//                         in_funct3, in_funct7, in_imm)
//   wr_en / wr_ready    - memory write handshake carrying wr_addr / wr_data
//   count, full, busy   - words written this session, DEPTH reached, session running
//   err_opcode, err_imm - sticky error flags, cleared by start
// Optional feature: define INST_ENC_IMM_CHECK_EN to range-check immediates on acceptance.
module inst_encoder #(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              busy,
    output logic              err_opcode,
    output logic              err_imm
);

    typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_U    = 7'b0110111;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] WORD_C  = ADDR_W'(4);

    state_t              state_q, state_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     issued_q, issued_d;
    logic                busy_q, busy_d;
    logic                full_q, full_d;
    logic                err_opcode_q, err_opcode_d;
    logic                err_imm_q, err_imm_d;

    logic [31:0]         enc_word;
    logic                op_ok;
    logic                imm_bad;
    logic                accept;
    logic                wr_fire;

    // Field packing; op_ok flags opcodes this encoder knows how to emit.
    always_comb begin
        enc_word = '0;
        op_ok    = 1'b1;
        case (in_opcode)
            OP_R:           enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            OP_LOAD,
            OP_IMM:         enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            OP_S:           enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            OP_B:           enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                        in_imm[4:1], in_imm[11], in_opcode};
            OP_U:           enc_word = {in_imm[31:12], in_rd, in_opcode};
            default:        op_ok    = 1'b0;
        endcase
    end

`ifdef INST_ENC_IMM_CHECK_EN
    // Sign-fit test: every bit above the field's top bit must equal that top bit.
    always_comb begin
        imm_bad = 1'b0;
        case (in_opcode)
            OP_LOAD, OP_IMM, OP_S:
                imm_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            OP_B:
                imm_bad = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
            OP_U:
                imm_bad = |in_imm[11:0];
            default:
                imm_bad = 1'b0;
        endcase
    end
`else
    assign imm_bad = 1'b0;
`endif

    // Accept only when the output slot is free or draining this cycle, and never
    // more bundles than the session can still write.
    assign in_ready = (state_q == RUN) && !start && (!wr_en_q || wr_ready) && (issued_q < DEPTH_C);
    assign accept   = in_valid && in_ready;
    assign wr_fire  = wr_en_q && wr_ready;

    always_comb begin
        state_d      = state_q;
        wr_en_d      = wr_en_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        count_d      = count_q;
        issued_d     = issued_q;
        err_opcode_d = err_opcode_q;
        err_imm_d    = err_imm_q;
        if (start) begin
            // start wins over everything, including a write completing this cycle
            state_d      = RUN;
            wr_en_d      = 1'b0;
            wr_addr_d    = BASE_ADDR;
            count_d      = '0;
            issued_d     = '0;
            err_opcode_d = 1'b0;
            err_imm_d    = 1'b0;
        end else begin
            if (wr_fire) begin
                wr_en_d   = 1'b0;
                wr_addr_d = wr_addr_q + WORD_C;
                count_d   = count_q + 1'b1;
                if (state_q == RUN && count_d == DEPTH_C) begin
                    state_d = FULL;
                end
            end
            if (accept) begin
                if (!op_ok) begin
                    err_opcode_d = 1'b1;
                end else if (imm_bad) begin
                    err_imm_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_data_d = enc_word;
                    issued_d  = issued_q + 1'b1;
                end
            end
        end
        busy_d = (state_d == RUN);
        full_d = (state_d == FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= BASE_ADDR;
            wr_data_q    <= '0;
            count_q      <= '0;
            issued_q     <= '0;
            busy_q       <= 1'b0;
            full_q       <= 1'b0;
            err_opcode_q <= 1'b0;
            err_imm_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            count_q      <= count_d;
            issued_q     <= issued_d;
            busy_q       <= busy_d;
            full_q       <= full_d;
            err_opcode_q <= err_opcode_d;
            err_imm_q    <= err_imm_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign count      = count_q;
    assign busy       = busy_q;
    assign full       = full_q;
    assign err_opcode = err_opcode_q;
    assign err_imm    = err_imm_q;

endmodule
